conv_router_v3: RTL

//  Parametrised successor of the conv window router: walks a conv layer's output space (oy rows x ox columns in

---
 rtl/conv_router_pkg.sv | 28 ++
 rtl/conv_win_clamp.sv | 36 +++
 rtl/conv_router_v3.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_router_pkg.sv
// rtl/conv_router_pkg.sv - shared types, default widths and clamp helpers for the conv router
// Purpose: FSM state enum, default field widths and integer clamp/saturate helpers used by the
//          router top and the window clamp.
// Ports:   none (package).
package conv_router_pkg;

    localparam int IDX_W_DEF = 16;
    localparam int CFG_W_DEF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Clamp v into [0, max]; used for pad counts that must not wrap.
    function automatic int sat_int(input int v, input int max);
        return (v < 0) ? 0 : ((v > max) ? max : v);
    endfunction

endpackage

// File: rtl/conv_win_clamp.sv
// rtl/conv_win_clamp.sv - clamps a signed window [cs, ce] to [0, lim-1] and reports pad counts
// Purpose: combinational window clamp for one axis.
// Ports:   cs, ce      in  signed IDX_W+1  window start / end (may lie outside the tensor)
//          lim         in  IDX_W           axis length
//          start_idx   out IDX_W           max(cs, 0)
//          end_idx     out IDX_W           min(ce, lim-1)
//          west_pad    out CFG_W           zero columns before start_idx, saturating
//          east_pad    out CFG_W           zero columns after end_idx, saturating
module conv_win_clamp
    import conv_router_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int CFG_W = CFG_W_DEF
) (
    input  logic signed [IDX_W:0]   cs,
    input  logic signed [IDX_W:0]   ce,
    input  logic [IDX_W-1:0]        lim,
    output logic [IDX_W-1:0]        start_idx,
    output logic [IDX_W-1:0]        end_idx,
    output logic [CFG_W-1:0]        west_pad,
    output logic [CFG_W-1:0]        east_pad
);

    localparam int PAD_MAX = (2 ** CFG_W) - 1;

    int hi;

    always_comb begin
        hi        = int'(lim) - 1;
        start_idx = IDX_W'(max_int(int'(cs), 0));
        end_idx   = IDX_W'(min_int(int'(ce), hi));
        west_pad  = CFG_W'(sat_int(-int'(cs), PAD_MAX));
        east_pad  = CFG_W'(sat_int(int'(ce) - hi, PAD_MAX));
    end

endmodule

// File: rtl/conv_router_v3.sv
// rtl/conv_router_v3.sv - conv layer output-space walker emitting row/column window descriptors
// Purpose: walks oy rows x ox columns in SLAB_W-wide slabs, one registered descriptor per step,
//          with valid/ready backpressure and config checking.
// Ports:   clk, reset (sync, active-high), en (start), k/s/p, ox/oy/ix/iy (config),
//          out_valid/out_ready (descriptor handshake), row_idx/row_vld (kernel rows),
//          west_pad/east_pad/slab_num/reg_start_idx/reg_end_idx (column window),
//          conv_end (last descriptor), busy (RUN), cfg_err (rejected start pulse),
//          stall_cnt (only with CONV_ROUTER_STALL_CNT_EN defined).
module conv_router_v3
    import conv_router_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int CFG_W  = CFG_W_DEF,
    parameter int K_MAX  = 7,
    parameter int SLAB_W = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic [CFG_W-1:0]               k,
    input  logic [CFG_W-1:0]               s,
    input  logic [CFG_W-1:0]               p,
    input  logic [IDX_W-1:0]               ox,
    input  logic [IDX_W-1:0]               oy,
    input  logic [IDX_W-1:0]               ix,
    input  logic [IDX_W-1:0]               iy,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [K_MAX*IDX_W-1:0]         row_idx,
    output logic [K_MAX-1:0]               row_vld,
    output logic [CFG_W-1:0]               west_pad,
    output logic [CFG_W-1:0]               east_pad,
    output logic [$clog2(SLAB_W+1)-1:0]    slab_num,
    output logic [IDX_W-1:0]               reg_start_idx,
    output logic [IDX_W-1:0]               reg_end_idx,
    output logic                           conv_end,
    output logic                           busy,
`ifdef CONV_ROUTER_STALL_CNT_EN
    output logic [31:0]                    stall_cnt,
`endif
    output logic                           cfg_err
);

    localparam int SW   = IDX_W + 1;
    localparam int SN_W = $clog2(SLAB_W + 1);

    state_t state_q, state_d;

    logic [CFG_W-1:0]      k_q, s_q, p_q;
    logic [IDX_W-1:0]      ox_q, oy_q, ix_q, iy_q;
    logic [IDX_W-1:0]      ox_idx_q, oy_idx_q;
    logic signed [SW-1:0]  rb_q, cs_q;

    logic start, step, finish, err_d;
    logic cfg_ok, accept, last_col, last_row;

    assign cfg_ok = (k != '0) && (s != '0) && (ox != '0) && (oy != '0) && (ix != '0) &&
                    (iy != '0) && (int'(k) <= K_MAX);
    assign accept   = out_valid && out_ready;
    assign last_col = (SW'(ox_idx_q) + SW'(SLAB_W)) >= SW'(ox_q);
    assign last_row = oy_idx_q == (oy_q - IDX_W'(1));
    assign busy     = (state_q == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    if (cfg_ok) begin
                        state_d = ST_RUN;
                        start   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (last_col && last_row) begin
                        state_d = ST_IDLE;
                        finish  = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // On the start cycle the descriptor is built from the live cfg inputs so the first
    // beat can be presented the very next cycle.
    logic [CFG_W-1:0]     k_c, s_c, p_c;
    logic [IDX_W-1:0]     ox_c, oy_c, ix_c, iy_c;
    logic [IDX_W-1:0]     ox_n, oy_n, rem;
    logic signed [SW-1:0] rb_n, cs_n, ce_n, neg_p, r;
    logic [SW-1:0]        span;
    logic [SN_W-1:0]      sn_n;
    logic [K_MAX*IDX_W-1:0] ri_n;
    logic [K_MAX-1:0]     rv_n;
    logic                 end_n;

    assign k_c  = start ? k  : k_q;
    assign s_c  = start ? s  : s_q;
    assign p_c  = start ? p  : p_q;
    assign ox_c = start ? ox : ox_q;
    assign oy_c = start ? oy : oy_q;
    assign ix_c = start ? ix : ix_q;
    assign iy_c = start ? iy : iy_q;
    assign neg_p = -$signed(SW'(p_c));

    // Bases advance by addition only: +s per output row, +SLAB_W*s per slab.
    always_comb begin
        ox_n = ox_idx_q;
        oy_n = oy_idx_q;
        rb_n = rb_q;
        cs_n = cs_q;
        if (start) begin
            ox_n = '0;
            oy_n = '0;
            rb_n = neg_p;
            cs_n = neg_p;
        end else if (last_col) begin
            ox_n = '0;
            oy_n = oy_idx_q + IDX_W'(1);
            rb_n = rb_q + $signed(SW'(s_q));
            cs_n = neg_p;
        end else begin
            ox_n = ox_idx_q + IDX_W'(SLAB_W);
            cs_n = cs_q + $signed(SW'(SLAB_W) * SW'(s_q));
        end
    end

    always_comb begin
        rem   = ox_c - ox_n;
        sn_n  = (rem >= IDX_W'(SLAB_W)) ? SN_W'(SLAB_W) : SN_W'(rem);
        span  = (SW'(sn_n) - SW'(1)) * SW'(s_c) + SW'(k_c) - SW'(1);
        ce_n  = cs_n + $signed(span);
        end_n = ((SW'(ox_n) + SW'(SLAB_W)) >= SW'(ox_c)) && (oy_n == (oy_c - IDX_W'(1)));
        ri_n  = '0;
        rv_n  = '0;
        r     = '0;
        for (int i = 0; i < K_MAX; i++) begin
            r = rb_n + $signed(SW'(i));
            if ((i < int'(k_c)) && !r[SW-1] && (r < $signed({1'b0, iy_c}))) begin
                rv_n[i]              = 1'b1;
                ri_n[i*IDX_W +: IDX_W] = r[IDX_W-1:0];
            end
        end
    end

    logic [IDX_W-1:0] st_n, en_idx_n;
    logic [CFG_W-1:0] wp_n, ep_n;

    conv_win_clamp #(.IDX_W(IDX_W), .CFG_W(CFG_W)) u_col_clamp (
        .cs        (cs_n),
        .ce        (ce_n),
        .lim       (ix_c),
        .start_idx (st_n),
        .end_idx   (en_idx_n),
        .west_pad  (wp_n),
        .east_pad  (ep_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q <= '0; s_q <= '0; p_q <= '0;
            ox_q <= '0; oy_q <= '0; ix_q <= '0; iy_q <= '0;
            ox_idx_q <= '0; oy_idx_q <= '0; rb_q <= '0; cs_q <= '0;
            out_valid <= 1'b0; conv_end <= 1'b0; cfg_err <= 1'b0;
            row_idx <= '0; row_vld <= '0; west_pad <= '0; east_pad <= '0;
            slab_num <= '0; reg_start_idx <= '0; reg_end_idx <= '0;
        end else begin
            cfg_err <= err_d;
            if (start) begin
                k_q <= k; s_q <= s; p_q <= p;
                ox_q <= ox; oy_q <= oy; ix_q <= ix; iy_q <= iy;
            end
            if (start || step) begin
                ox_idx_q      <= ox_n;
                oy_idx_q      <= oy_n;
                rb_q          <= rb_n;
                cs_q          <= cs_n;
                out_valid     <= 1'b1;
                row_idx       <= ri_n;
                row_vld       <= rv_n;
                west_pad      <= wp_n;
                east_pad      <= ep_n;
                slab_num      <= sn_n;
                reg_start_idx <= st_n;
                reg_end_idx   <= en_idx_n;
                conv_end      <= end_n;
            end else if (finish) begin
                out_valid <= 1'b0;
                conv_end  <= 1'b0;
            end
        end
    end

`ifdef CONV_ROUTER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || start)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule
